timer_sched: RTL and testbench

Programmable period scheduler for the segment/auto-scan logic. It owns a WIDTH-bit period counter and a CNT_W-bit repeat counter. It accepts a configuration through a valid/ready handshake, then on start emits one-cycle tick pulses every limit+1 cycles. It runs either a fixed number of periods, ending with a done pulse, or free-runs until stopped. Consumers use tick to advance digit scanning or counter updates.

---
 rtl/timer_sched.sv | 122 ++++++++++++
 tb/tb_timer_sched.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_sched.sv
// timer_sched: programmable period scheduler.
// Accepts a limit/count configuration over a valid/ready handshake. Once started it
// emits a one-cycle tick every limit+1 cycles. A non-zero count ends the run with a
// done pulse on the final tick; a zero count free-runs until stopped.
`timescale 1ns/1ps

module timer_sched #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [WIDTH-1:0] i_cfg_limit,
    input  logic [CNT_W-1:0] i_cfg_count,
    input  logic             i_start,
    input  logic             i_stop,
    output logic             o_busy,
    output logic             o_tick,
    output logic             o_done,
    output logic [CNT_W-1:0] o_ticks_left
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StRun   = 2'd2
    } state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_counter;
    logic [WIDTH-1:0] r_limit;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_ticks_left;
    logic             r_tick;
    logic             r_done;

    logic             w_cfg_fire;
    logic             w_terminal;
    logic             w_counted;
    logic             w_last;

    // Handshake and period/termination decodes
    always_comb begin
        o_cfg_ready = (r_state != StRun);
        w_cfg_fire  = i_cfg_valid && o_cfg_ready;
        w_terminal  = (r_counter == r_limit);
        w_counted   = (r_count != '0);
        // Only a counted run can finish; free-run keeps ticks_left at 0
        w_last      = w_counted && (r_ticks_left == CNT_W'(1));
    end

    // Scheduler FSM with registered tick/done pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_counter    <= '0;
            r_limit      <= '0;
            r_count      <= '0;
            r_ticks_left <= '0;
            r_tick       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_cfg_fire) begin
                        r_limit      <= i_cfg_limit;
                        r_count      <= i_cfg_count;
                        r_ticks_left <= i_cfg_count;
                        r_state      <= StArmed;
                    end
                end
                StArmed: begin
                    // A configuration transfer takes precedence over start
                    if (w_cfg_fire) begin
                        r_limit      <= i_cfg_limit;
                        r_count      <= i_cfg_count;
                        r_ticks_left <= i_cfg_count;
                    end else if (i_start && !i_stop) begin
                        r_state      <= StRun;
                        r_counter    <= '0;
                        r_ticks_left <= r_count;
                    end
                end
                StRun: begin
                    if (i_stop) begin
                        // Stop suppresses any pulse due this cycle; ticks_left holds
                        r_state   <= StArmed;
                        r_counter <= '0;
                    end else if (w_terminal) begin
                        r_counter <= '0;
                        r_tick    <= 1'b1;
                        if (w_counted && (r_ticks_left != '0)) begin
                            r_ticks_left <= r_ticks_left - CNT_W'(1);
                        end
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= StArmed;
                        end
                    end else begin
                        r_counter <= r_counter + WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Output mapping
    always_comb begin
        o_busy       = (r_state == StRun);
        o_tick       = r_tick;
        o_done       = r_done;
        o_ticks_left = r_ticks_left;
    end

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched: reset, counted run, free-run, stop, config rules,
// back-to-back restart and asynchronous reset during a run.
`timescale 1ns/1ps

module tb_timer_sched;

    localparam int unsigned WIDTH = 25;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_limit;
    logic [CNT_W-1:0] cfg_count;
    logic             start;
    logic             stop;
    logic             busy;
    logic             tick;
    logic             done;
    logic [CNT_W-1:0] ticks_left;

    int n_checks = 0;
    int n_errors = 0;

    // Expected values for the back-to-back restart sequence, cycles 1..9
    int exp_tick [1:9] = '{0, 1, 0, 1, 0, 0, 1, 0, 1};
    int exp_done [1:9] = '{0, 0, 0, 1, 0, 0, 0, 0, 1};
    int exp_busy [1:9] = '{1, 1, 1, 0, 1, 1, 1, 1, 0};
    int exp_left [1:9] = '{2, 1, 1, 0, 2, 2, 1, 1, 0};

    always #5 clk = ~clk;

    timer_sched #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cfg_valid  (cfg_valid),
        .o_cfg_ready  (cfg_ready),
        .i_cfg_limit  (cfg_limit),
        .i_cfg_count  (cfg_count),
        .i_start      (start),
        .i_stop       (stop),
        .o_busy       (busy),
        .o_tick       (tick),
        .o_done       (done),
        .o_ticks_left (ticks_left)
    );

    // Advance one clock; outputs are observed 1ns after the rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [WIDTH-1:0] lim, input logic [CNT_W-1:0] cnt);
        cfg_valid = 1'b1;
        cfg_limit = lim;
        cfg_count = cnt;
        cyc();
        cfg_valid = 1'b0;
    endtask

    initial begin
        // ---- Reset with random inputs ----
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_limit = '0;
        cfg_count = '0;
        start     = 1'b0;
        stop      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cfg_valid = 1'($urandom);
            cfg_limit = WIDTH'($urandom);
            cfg_count = CNT_W'($urandom);
            start     = 1'($urandom);
            stop      = 1'($urandom);
            cyc();
            chk("rst_busy", busy, 0);
            chk("rst_tick", tick, 0);
            chk("rst_done", done, 0);
            chk("rst_left", ticks_left, 0);
            chk("rst_ready", cfg_ready, 1);
        end
        cfg_valid = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        rst_n     = 1'b1;
        cyc();

        // ---- Start before any configuration is ignored ----
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("idle_start_busy", busy, 0);
        cyc();
        chk("idle_start_busy2", busy, 0);

        // ---- Counted run: limit=4, count=3; cfg_valid during RUN ignored ----
        cfg(25'd4, 8'd3);
        chk("cnt_cfg_left", ticks_left, 3);
        chk("cnt_cfg_busy", busy, 0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("cnt_e0_busy", busy, 1);
        chk("cnt_e0_tick", tick, 0);
        for (int c = 1; c <= 15; c++) begin
            cyc();
            chk("cnt_tick", tick, (c % 5 == 0) ? 1 : 0);
            chk("cnt_left", ticks_left, 3 - c / 5);
            chk("cnt_done", done, (c == 15) ? 1 : 0);
            chk("cnt_busy", busy, (c < 15) ? 1 : 0);
            chk("cnt_ready", cfg_ready, (c == 15) ? 1 : 0);
            if (c == 2) begin
                cfg_valid = 1'b1;
                cfg_limit = 25'd9;
                cfg_count = 8'd7;
            end
            if (c == 3) cfg_valid = 1'b0;
        end
        cyc();
        chk("cnt_post_tick", tick, 0);
        chk("cnt_post_done", done, 0);
        chk("cnt_post_busy", busy, 0);

        // ---- Free-run: limit=0, count=0, then stop ----
        cfg(25'd0, 8'd0);
        chk("fr_cfg_left", ticks_left, 0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("fr_e0_busy", busy, 1);
        chk("fr_e0_tick", tick, 0);
        for (int c = 1; c <= 5; c++) begin
            cyc();
            chk("fr_tick", tick, 1);
            chk("fr_done", done, 0);
            chk("fr_left", ticks_left, 0);
            chk("fr_busy", busy, 1);
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("fr_stop_tick", tick, 0);
        chk("fr_stop_busy", busy, 0);
        chk("fr_stop_done", done, 0);

        // ---- Stop in the terminal cycle: limit=2, count=1 ----
        cfg(25'd2, 8'd1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("st_tick", tick, 0);
        chk("st_done", done, 0);
        chk("st_busy", busy, 0);
        chk("st_ready", cfg_ready, 1);
        chk("st_left", ticks_left, 1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("st_re_busy", busy, 1);
        for (int c = 1; c <= 3; c++) begin
            cyc();
            chk("st_re_tick", tick, (c == 3) ? 1 : 0);
            chk("st_re_done", done, (c == 3) ? 1 : 0);
            chk("st_re_busy", busy, (c == 3) ? 0 : 1);
        end
        chk("st_re_left", ticks_left, 0);

        // ---- Reconfigure to limit=1, count=2 with start in same cycle ----
        cfg_valid = 1'b1;
        cfg_limit = 25'd1;
        cfg_count = 8'd2;
        start     = 1'b1;
        cyc();
        cfg_valid = 1'b0;
        chk("cs_busy", busy, 0);
        chk("cs_left", ticks_left, 2);

        // ---- Start held high through done: immediate restart ----
        cyc();
        chk("b2b_e0_busy", busy, 1);
        chk("b2b_e0_tick", tick, 0);
        for (int c = 1; c <= 9; c++) begin
            cyc();
            chk("b2b_tick", tick, exp_tick[c]);
            chk("b2b_done", done, exp_done[c]);
            chk("b2b_busy", busy, exp_busy[c]);
            chk("b2b_left", ticks_left, exp_left[c]);
        end
        start = 1'b0;
        cyc();
        chk("b2b_end_busy", busy, 0);
        chk("b2b_end_tick", tick, 0);

        // ---- Asynchronous reset mid-RUN while tick is high ----
        cfg(25'd3, 8'd5);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) cyc();
        chk("ar_pre_tick", tick, 1);
        chk("ar_pre_left", ticks_left, 4);
        rst_n = 1'b0;
        #1;
        chk("ar_tick", tick, 0);
        chk("ar_busy", busy, 0);
        chk("ar_done", done, 0);
        chk("ar_left", ticks_left, 0);
        chk("ar_ready", cfg_ready, 1);
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            chk("ar_post_tick", tick, 0);
            chk("ar_post_busy", busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
